// File: rtl/pingpang_ram_ctrl.sv
// pingpang_ram_ctrl
//   Two-bank (ping-pong) frame buffer in front of the ARM output selector.
//   Correlation words fill one bank while the previously completed bank is
//   streamed out. Streaming pauses while the selector serves return3 data, so
//   no word is lost on the ARM bus.
//
// Ports
//   clk                    system clock
//   rst                    asynchronous reset, active high
//   din / din_valid        correlation word and its write strobe
//   return3_data_flag      1 = selector busy with return3, hold the read side
//   pingpang_ram_data      streamed word (holds its last value between words)
//   pingpang_ram_data_flag pingpang_ram_data carries a new word this cycle
//   frame_done             pulses together with the flag of a frame's last word
//   ovf                    sticky: a word was dropped because both banks were full
//   ovf_cnt                saturating dropped-word count
//
// Configuration
//   PP_OVF_CNT_EN  defined: ovf_cnt counts dropped words (saturates at 16'hFFFF).
//                  undefined: ovf_cnt is tied to zero and no counter is built.

module pingpang_ram_ctrl #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic              return3_data_flag,
  output logic [DATA_W-1:0] pingpang_ram_data,
  output logic              pingpang_ram_data_flag,
  output logic              frame_done,
  output logic              ovf,
  output logic [15:0]       ovf_cnt
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] AddrOne  = ADDR_W'(1);

  typedef enum logic [0:0] {StIdle, StStream} rd_state_e;

  logic [DATA_W-1:0] mem0 [DEPTH];
  logic [DATA_W-1:0] mem1 [DEPTH];

  logic              wr_bank_q, wr_bank_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [1:0]        bank_full_q, bank_full_d;
  rd_state_e         rd_state_q, rd_state_d;
  logic              rd_bank_q, rd_bank_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              flag_q, flag_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;

  logic              wr_en;
  logic              wr_drop;
  logic              rd_issue;
  logic [DATA_W-1:0] rd_word;

  // The writer only ever points at a full bank when both banks are full.
  assign wr_en    = din_valid & ~bank_full_q[wr_bank_q];
  assign wr_drop  = din_valid &  bank_full_q[wr_bank_q];
  assign rd_issue = (rd_state_q == StStream) & ~return3_data_flag;
  assign rd_word  = rd_bank_q ? mem1[rd_addr_q] : mem0[rd_addr_q];

  always_comb begin
    wr_bank_d   = wr_bank_q;
    wr_addr_d   = wr_addr_q;
    bank_full_d = bank_full_q;
    rd_state_d  = rd_state_q;
    rd_bank_d   = rd_bank_q;
    rd_addr_d   = rd_addr_q;
    ovf_d       = ovf_q | wr_drop;
    flag_d      = rd_issue;
    done_d      = rd_issue & (rd_addr_q == LastAddr);
    data_d      = rd_issue ? rd_word : data_q;

    if (wr_en) begin
      wr_addr_d = wr_addr_q + AddrOne;
      if (wr_addr_q == LastAddr) begin
        bank_full_d[wr_bank_q] = 1'b1;
        wr_bank_d              = ~wr_bank_q;
      end
    end

    // Reader and writer never touch the same bank, so set/clear cannot collide.
    unique case (rd_state_q)
      StIdle: begin
        if (|bank_full_q) begin
          rd_state_d = StStream;
          rd_addr_d  = '0;
          rd_bank_d  = (&bank_full_q) ? ~wr_bank_q : bank_full_q[1];
        end
      end
      StStream: begin
        if (rd_issue) begin
          rd_addr_d = rd_addr_q + AddrOne;
          if (rd_addr_q == LastAddr) begin
            bank_full_d[rd_bank_q] = 1'b0;
            rd_state_d             = StIdle;
          end
        end
      end
    endcase
  end

  // Storage is not reset: contents survive rst, only the bookkeeping is cleared.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_bank_q) mem1[wr_addr_q] <= din;
      else           mem0[wr_addr_q] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank_q   <= 1'b0;
      wr_addr_q   <= '0;
      bank_full_q <= 2'b00;
      rd_state_q  <= StIdle;
      rd_bank_q   <= 1'b0;
      rd_addr_q   <= '0;
      data_q      <= '0;
      flag_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      wr_bank_q   <= wr_bank_d;
      wr_addr_q   <= wr_addr_d;
      bank_full_q <= bank_full_d;
      rd_state_q  <= rd_state_d;
      rd_bank_q   <= rd_bank_d;
      rd_addr_q   <= rd_addr_d;
      data_q      <= data_d;
      flag_q      <= flag_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
    end
  end

  assign pingpang_ram_data      = data_q;
  assign pingpang_ram_data_flag = flag_q;
  assign frame_done             = done_q;
  assign ovf                    = ovf_q;

`ifdef PP_OVF_CNT_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (wr_drop && (ovf_cnt_q != 16'hFFFF)) ovf_cnt_d = ovf_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_cnt_q <= 16'd0;
    else     ovf_cnt_q <= ovf_cnt_d;
  end

  assign ovf_cnt = ovf_cnt_q;
`else
  assign ovf_cnt = 16'd0;
`endif

endmodule
